axi_lite_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register bank; next generation of the team's fixed 4 x 32-bit AXI4-Lite peripheral.
- Adds configurable register count and data width, byte strobes, and per-register modes: read/write, read-only (hardware-driven) and write-one-to-clear (hardware-set status).
- Adds SLVERR responses for illegal accesses.
- Sits behind the PS/VIP AXI master; drives control registers into user logic and returns status from it.

---
 rtl/axi_lite_regfile.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank with per-register RW / read-only / write-one-to-clear modes.
// Independent write and read channel FSMs; illegal accesses answer SLVERR.
module axi_lite_regfile #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS           = 8,
  parameter logic [31:0] RO_MASK            = 32'h0,
  parameter logic [31:0] W1C_MASK           = 32'h0
) (
  input  logic                                     ACLK,
  input  logic                                     ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-1:0]                      wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   hw_in,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   hw_set
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned NB       = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(NB);
  localparam int unsigned IDX_W    = AW - ADDR_LSB;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  w_state_e                   w_state_q, w_state_d;
  logic                       awready_q, awready_d, wready_q, wready_d;
  logic                       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [IDX_W-1:0]           awidx_q, awidx_d;
  logic [DW-1:0]              wdata_q, wdata_d;
  logic [NB-1:0]              wstrb_q, wstrb_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]        wr_pulse_q, wr_pulse_d;

  r_state_e                   r_state_q, r_state_d;
  logic                       arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0]              rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;

  logic                       aw_hs, w_hs, commit, werr;
  logic [IDX_W-1:0]           widx, ridx;
  logic [DW-1:0]              cdata, bmask, rd_val;
  logic [NB-1:0]              cstrb;
  logic                       rd_err;
  logic                       unused_sigs;

  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0], hw_in, hw_set};

  assign aw_hs = awready_q & S_AXI_AWVALID;
  assign w_hs  = wready_q & S_AXI_WVALID;
  // The commit may happen on the same edge the last half is accepted, so bypass the latches.
  assign widx  = aw_hs ? S_AXI_AWADDR[AW-1:ADDR_LSB] : awidx_q;
  assign cdata = w_hs ? S_AXI_WDATA : wdata_q;
  assign cstrb = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign ridx  = S_AXI_ARADDR[AW-1:ADDR_LSB];

  always_comb begin
    werr = !(32'(widx) < NUM_REGS);
    for (int i = 0; i < NUM_REGS; i++)
      if (RO_MASK[i] && widx == IDX_W'(i)) werr = 1'b1;
    for (int b = 0; b < NB; b++)
      bmask[b*8 +: 8] = {8{cstrb[b]}};
  end

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awidx_d   = S_AXI_AWADDR[AW-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_done_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_done_d && w_done_d) begin
          commit    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = werr ? 2'b10 : 2'b00;
          w_state_d = W_RESP;
        end else begin
          awready_d = !aw_done_d;
          wready_d  = !w_done_d;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // hw_set is ORed after the bus clear so a simultaneous set always wins.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_pulse_d[i] = commit && !werr && widx == IDX_W'(i);
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end else if (W1C_MASK[i]) begin
        if (wr_pulse_d[i]) regs_d[i] = regs_q[i] & ~(cdata & bmask);
        regs_d[i] = regs_d[i] | hw_set[i*DW +: DW];
      end else if (wr_pulse_d[i]) begin
        regs_d[i] = (regs_q[i] & ~bmask) | (cdata & bmask);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    rd_err = !(32'(ridx) < NUM_REGS);
    for (int i = 0; i < NUM_REGS; i++)
      if (ridx == IDX_W'(i)) rd_val = RO_MASK[i] ? hw_in[i*DW +: DW] : regs_q[i];
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (arready_q && S_AXI_ARVALID) begin
          rvalid_d  = 1'b1;
          rdata_d   = rd_err ? '0 : rd_val;
          rresp_d   = rd_err ? 2'b10 : 2'b00;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_out       = regs_q;
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: 6 registers, reg2 read-only, reg3 write-one-to-clear.
module tb_axi_lite_regfile;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 6;

  logic            clk, rst;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic [NR*DW-1:0] reg_out, hw_in, hw_set;
  logic [NR-1:0]   wr_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [NR];

  axi_lite_regfile #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR),
    .RO_MASK(32'h04), .W1C_MASK(32'h08)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .hw_in(hw_in), .hw_set(hw_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_hs, w_hs, b_hs, done;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    done = 0; resp = 2'bxx;
    for (int n = 0; n < 20 && !done; n++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (b_hs) resp = bresp;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      if (b_hs) done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL write_timeout: addr 0x%0h got no response, required one within 20 cycles", a);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp);
    bit ar_hs, r_hs, done;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    done = 0; d = 'x; resp = 2'bxx;
    for (int n = 0; n < 20 && !done; n++) begin
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (r_hs) begin d = rdata; resp = rresp; end
      @(negedge clk);
      if (ar_hs) arvalid = 1'b0;
      if (r_hs) done = 1;
    end
    arvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_timeout: addr 0x%0h got no data, required within 20 cycles", a);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [5:0] a, logic [31:0] d, logic [3:0] s,
                              logic [1:0] r, logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd;
    return v;
  endfunction

  vec_t vecs[$];
  logic [1:0]  resp;
  logic [31:0] rd;
  int          bv_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1; hw_set = '0;
    for (int i = 0; i < NR; i++) begin
      hw_in[i*DW +: DW] = 32'hDEAD_0000 + i;
      pulse_cnt[i] = 0;
    end
    hw_in[2*DW +: DW] = 32'hCAFE_F00D;

    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_reg_out", reg_out, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reg2 is read-only, reg3 is W1C (starts clear), 0x18/0x1C are beyond the bank
    vecs.push_back(mk(1, 6'h00, 32'h1, 4'hF, 2'b00, 0));
    vecs.push_back(mk(1, 6'h04, 32'h2, 4'hF, 2'b00, 0));
    vecs.push_back(mk(1, 6'h08, 32'h3, 4'hF, 2'b10, 0));
    vecs.push_back(mk(1, 6'h0C, 32'h4, 4'hF, 2'b00, 0));
    vecs.push_back(mk(1, 6'h10, 32'h5, 4'hF, 2'b00, 0));
    vecs.push_back(mk(1, 6'h14, 32'h6, 4'hF, 2'b00, 0));
    vecs.push_back(mk(1, 6'h18, 32'h7, 4'hF, 2'b10, 0));
    vecs.push_back(mk(1, 6'h1C, 32'h8, 4'hF, 2'b10, 0));
    vecs.push_back(mk(0, 6'h00, 0, 0, 2'b00, 32'h1));
    vecs.push_back(mk(0, 6'h04, 0, 0, 2'b00, 32'h2));
    vecs.push_back(mk(0, 6'h08, 0, 0, 2'b00, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 6'h0C, 0, 0, 2'b00, 32'h0));
    vecs.push_back(mk(0, 6'h10, 0, 0, 2'b00, 32'h5));
    vecs.push_back(mk(0, 6'h14, 0, 0, 2'b00, 32'h6));
    vecs.push_back(mk(0, 6'h18, 0, 0, 2'b10, 32'h0));
    vecs.push_back(mk(0, 6'h1C, 0, 0, 2'b10, 32'h0));
    vecs.push_back(mk(1, 6'h00, 32'h1122_3344, 4'hF, 2'b00, 0));
    vecs.push_back(mk(1, 6'h00, 32'hAABB_CCDD, 4'b0101, 2'b00, 0));
    vecs.push_back(mk(0, 6'h00, 0, 0, 2'b00, 32'h11BB_33DD));
    vecs.push_back(mk(1, 6'h00, 32'hFFFF_FFFF, 4'b0000, 2'b00, 0));
    vecs.push_back(mk(0, 6'h03, 0, 0, 2'b00, 32'h11BB_33DD));

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
      end else begin
        do_read(vecs[i].addr, rd, resp);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      end
    end

    check("pulse_reg0", pulse_cnt[0], 4);
    check("pulse_reg1", pulse_cnt[1], 1);
    check("pulse_reg2", pulse_cnt[2], 0);
    check("pulse_reg3", pulse_cnt[3], 1);
    check("pulse_reg4", pulse_cnt[4], 1);
    check("pulse_reg5", pulse_cnt[5], 1);
    check("reg_out_0", reg_out[0 +: DW], 32'h11BB_33DD);
    check("reg_out_1", reg_out[DW +: DW], 32'h2);

    // W three cycles ahead of AW, then BREADY withheld for four cycles
    @(negedge clk);
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    wvalid = 1'b0;
    check("early_w_wready_low", wready, 0);
    check("early_w_no_bvalid", bvalid, 0);
    repeat (2) @(negedge clk);
    check("early_w_awready", awready, 1);
    awaddr = 6'h10; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    bv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (bvalid && !awready && !wready && bresp == 2'b00) bv_cnt++;
      @(negedge clk);
    end
    check("bresp_hold_cycles", bv_cnt, 4);
    bready = 1'b1;
    @(negedge clk);
    check("bvalid_dropped", bvalid, 0);
    check("awready_back", awready, 1);
    check("early_w_single_pulse", pulse_cnt[4], 2);
    check("early_w_value", reg_out[4*DW +: DW], 32'h55);

    // W1C: hardware sets, bus clears, set beats clear in the same cycle
    @(negedge clk);
    hw_set[3*DW +: DW] = 32'hF;
    @(negedge clk);
    hw_set = '0;
    check("w1c_set", reg_out[3*DW +: DW], 32'hF);
    do_write(6'h0C, 32'h5, 4'hF, resp);
    check("w1c_bresp", resp, 2'b00);
    do_read(6'h0C, rd, resp);
    check("w1c_clear", rd, 32'hA);
    @(negedge clk);
    hw_set[3*DW +: DW] = 32'hF;
    @(negedge clk);
    hw_set = '0;
    awaddr = 6'h0C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    hw_set[3*DW +: DW] = 32'h1;
    check("w1c_ready_both", {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; hw_set = '0;
    check("w1c_race_bvalid", bvalid, 1);
    @(negedge clk);
    do_read(6'h0C, rd, resp);
    check("w1c_set_wins", rd, 32'hB);

    // read handshake on the commit edge returns the old contents
    @(negedge clk);
    rready = 1'b0; araddr = 6'h14; arvalid = 1'b1;
    awaddr = 6'h14; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("rw_same_rvalid", rvalid, 1);
    check("rw_same_old_data", rdata, 32'h6);
    check("rw_same_bvalid", bvalid, 1);
    rready = 1'b1;
    @(negedge clk);
    do_read(6'h14, rd, resp);
    check("rw_same_new_data", rd, 32'h77);

    // reset while a write response is pending
    @(negedge clk);
    bready = 1'b0; awaddr = 6'h04; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_bvalid", bvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bvalid", bvalid, 0);
    check("rst_mid_reg_out", reg_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; bready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_bvalid", bvalid, 0);
    do_write(6'h00, 32'h1234, 4'hF, resp);
    check("post_rst_bresp", resp, 2'b00);
    do_read(6'h00, rd, resp);
    check("post_rst_rdata", rd, 32'h1234);
    check("post_rst_reg1", reg_out[DW +: DW], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
